wb_host_master: RTL and testbench
=================================

WB_HOST_MASTER -- requirements
Module: wb_host_master

Interface
REQ-001 Parameter: TIMEOUT, 64, maximum number of bus cycles to wait for wbm_ack_i; legal range 2..65535.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, as listed below.
REQ-003 wb_clk_i  in  1  single clock; all state changes on the rising edge.
REQ-004 wb_rst_i  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid_i  in  1  command request.
REQ-006 cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
REQ-007 cmd_we_i  in  1  1 = write, 0 = read.
REQ-008 cmd_adr_i  in  32  byte address.
REQ-009 cmd_dat_i  in  32  write data.
REQ-010 cmd_sel_i  in  4  byte selects.
REQ-011 rsp_valid_o  out  1  response available.
REQ-012 rsp_ready_i  in  1  response consumed when high together with rsp_valid_o.
REQ-013 rsp_dat_o  out  32  read data; 0 for writes and errors.
REQ-014 rsp_err_o  out  1  1 = timeout, no ack received.
REQ-015 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
REQ-016 wbm_adr_o, wbm_dat_o  out  32 each; wbm_sel_o  out  4  Wishbone master address, data and selects.
REQ-017 wbm_dat_i  in  32; wbm_ack_i  in  1  slave read data and acknowledge.
REQ-018 busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, BUS, RESP.
REQ-020 IDLE: cmd_ready_o=1; on cmd_valid_i, the block SHALL register we/adr/dat/sel and go to BUS, with cyc/stb high from the next cycle.
REQ-021 BUS: wbm_cyc_o=wbm_stb_o=1, and the registered we/adr/dat/sel SHALL be held stable; cmd_ready_o=0.
REQ-022 BUS: a 16-bit wait counter SHALL start at 0 on entry and increment each cycle without ack.
REQ-023 BUS: on a cycle with wbm_ack_i=1, the block SHALL capture wbm_dat_i (reads only), set rsp_err_o=0, deassert cyc/stb at that edge, and go to RESP.
REQ-024 BUS: on a cycle with counter==TIMEOUT-1 and wbm_ack_i=0, the block SHALL deassert cyc/stb, set rsp_err_o=1, set rsp_dat_o=0, and go to RESP.
REQ-025 If ack and timeout occur in the same cycle, ack SHALL win (success response).
REQ-026 wbm_ack_i SHALL be ignored outside BUS, with no state change and no data capture.
REQ-027 RESP: rsp_valid_o=1, with rsp_dat_o/rsp_err_o held stable until rsp_ready_i=1; then the block SHALL go to IDLE.
REQ-028 cmd_ready_o SHALL be 0 in RESP; no new command is accepted in the same cycle as the response handshake.
REQ-029 Latency: command accepted at edge N -> cyc/stb high in cycle N+1; ack sampled at edge M -> rsp_valid_o high in cycle M+1; minimum command-to-response is 2 cycles.
REQ-030 Only one transaction SHALL be outstanding at a time; cyc and stb SHALL always be equal.
REQ-031 wbm_dat_o SHALL be driven with the registered data on reads too, but is don't-care to the slave.

Reset
REQ-032 While wb_rst_i=0, the block SHALL immediately (asynchronously) force: state=IDLE, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_adr_o=wbm_dat_o=0, wbm_sel_o=0, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, busy_o=0, counter=0.
REQ-033 cmd_ready_o SHALL be 0 while in reset and 1 in the first cycle after release.
REQ-034 Reset asserted during BUS SHALL drop cyc/stb without waiting for the edge; no response SHALL be produced for the aborted command.

Verification
REQ-035 Write with 1-cycle-ack slave: cmd we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF -> exactly one cycle with cyc/stb/we high and those values on the bus; then rsp_valid_o, err=0, rsp_dat_o=0.
REQ-036 Read with 3-wait-state slave returning 0x1234_5678 -> cyc/stb high for 4 cycles; rsp_dat_o=0x1234_5678, err=0; response held 5 cycles with rsp_ready_i=0, then cleared one cycle after ready.
REQ-037 Timeout, TIMEOUT=8, slave never acks -> cyc/stb high for exactly 8 cycles, then rsp_err_o=1 and rsp_dat_o=0.
REQ-038 Ack in the 8th cycle with TIMEOUT=8 (simultaneous with timeout) -> success response, err=0, data captured.
REQ-039 Reset pulse during BUS in read wait -> cyc/stb low within the reset-low interval; after release cmd_ready_o=1, rsp_valid_o=0, and a spurious ack is ignored.
REQ-040 Back-to-back commands (cmd_valid_i held high, rsp_ready_i tied high) -> second command accepted only after the RESP->IDLE transition; cyc never overlaps across transactions.

Source files
------------

// File: rtl/wb_host_master.sv
// wb_host_master: turns single host commands into Wishbone classic cycles,
// one transaction at a time, and returns a response.
// A transaction that gets no slave ack within TIMEOUT cycles is abandoned
// and reported with an error response.
//
// Ports
//   wb_clk_i, wb_rst_i         clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake
//   cmd_we_i, cmd_adr_i,       command payload: write enable, byte address,
//   cmd_dat_i, cmd_sel_i       write data and byte selects
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_dat_o, rsp_err_o       read data (0 for writes and errors), timeout flag
//   wbm_cyc_o, wbm_stb_o,      Wishbone master controls
//   wbm_we_o
//   wbm_adr_o, wbm_dat_o,      Wishbone master address, data and selects
//   wbm_sel_o
//   wbm_dat_i, wbm_ack_i       Wishbone slave read data and acknowledge
//   busy_o                     high whenever a transaction is in progress
module wb_host_master #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Ready is gated by reset so it reads 0 while held in reset and 1 as soon
  // as reset releases, without waiting for a clock edge.
  assign cmd_ready_o = (state == IDLE) && wb_rst_i;
  assign busy_o      = (state != IDLE);

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            wbm_we_o  <= cmd_we_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
            wbm_sel_o <= cmd_sel_i;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wait_cnt  <= '0;
            state     <= BUS;
          end
        end

        BUS: begin
          // Ack is checked first so an ack on the last allowed cycle wins.
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? 32'd0 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else if (wait_cnt == LAST_WAIT) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master with a small parameterisable Wishbone
// slave (programmable wait states, optional never-ack, forced ack).
module tb_wb_host_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic [31:0] rdat;
  logic        ack;
  logic        busy;

  // slave model controls
  int unsigned ws;
  logic        slave_en;
  logic        force_ack;
  int unsigned wcnt;
  int unsigned cyc_cycles;

  int checks;
  int errors;

  wb_host_master #(.TIMEOUT(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (wdat),
    .wbm_sel_o   (sel),
    .wbm_dat_i   (rdat),
    .wbm_ack_i   (ack),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slave: acks in the (ws+1)-th cycle of a bus cycle when enabled.
  always @(posedge clk) begin
    if (cyc) wcnt <= wcnt + 1;
    else     wcnt <= 0;
  end
  assign ack = force_ack | (slave_en & cyc & stb & (wcnt == ws));

  // Bus monitor between edges: cyc/stb equal, no bus cycle during a response.
  always @(negedge clk) begin
    if (cyc) cyc_cycles <= cyc_cycles + 1;
    check("cyc_eq_stb", {31'd0, stb}, {31'd0, cyc});
    check("no_overlap", {31'd0, cyc & rsp_valid}, 32'd0);
  end

  // Present a command and hold it until the accepting edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    cmd_valid = 1'b1;
    cyc_cycles = 0;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0;
    rsp_ready = 0; rdat = 0; ws = 0; slave_en = 1; force_ack = 0;
    wcnt = 0; cyc_cycles = 0;

    // reset state
    step(); step();
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_cyc",   {31'd0, cyc},       32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_adr",   adr,                32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    step();

    // write, 1-cycle-ack slave
    ws = 0; slave_en = 1;
    issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    check("wr_cyc",   {31'd0, cyc},  32'd1);
    check("wr_we",    {31'd0, we},   32'd1);
    check("wr_adr",   adr,           32'h3000_0004);
    check("wr_dat",   wdat,          32'hDEAD_BEEF);
    check("wr_sel",   {28'd0, sel},  32'hF);
    check("wr_ready", {31'd0, cmd_ready}, 32'd0);
    check("wr_busy",  {31'd0, busy}, 32'd1);
    step();
    check("wr_cyc_end",  {31'd0, cyc},       32'd0);
    check("wr_ncyc",     cyc_cycles,         32'd1);
    check("wr_rvalid",   {31'd0, rsp_valid}, 32'd1);
    check("wr_err",      {31'd0, rsp_err},   32'd0);
    check("wr_rdat",     rsp_dat,            32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("wr_rvalid_clr", {31'd0, rsp_valid}, 32'd0);
    check("wr_idle_ready", {31'd0, cmd_ready}, 32'd1);

    // read, 3 wait states, slow response consumer
    ws = 3; rdat = 32'h1234_5678;
    issue(1'b0, 32'h0000_0100, 32'hAAAA_5555, 4'h3);
    check("rd_we", {31'd0, we}, 32'd0);
    step(); step(); step();
    check("rd_cyc_last", {31'd0, cyc},       32'd1);
    check("rd_no_rsp",   {31'd0, rsp_valid}, 32'd0);
    step();
    check("rd_ncyc",   cyc_cycles,         32'd4);
    check("rd_rvalid", {31'd0, rsp_valid}, 32'd1);
    check("rd_err",    {31'd0, rsp_err},   32'd0);
    check("rd_rdat",   rsp_dat,            32'h1234_5678);
    rdat = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rd_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("rd_hold_dat",   rsp_dat,            32'h1234_5678);
      check("rd_hold_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rd_rvalid_clr", {31'd0, rsp_valid}, 32'd0);

    // timeout, slave never acks
    slave_en = 0;
    issue(1'b0, 32'h0000_0200, 32'd0, 4'hF);
    for (int i = 0; i < 7; i++) step();
    check("to_cyc_8th", {31'd0, cyc},       32'd1);
    check("to_no_rsp",  {31'd0, rsp_valid}, 32'd0);
    step();
    check("to_ncyc",   cyc_cycles,         32'd8);
    check("to_cyc_end", {31'd0, cyc},      32'd0);
    check("to_rvalid", {31'd0, rsp_valid}, 32'd1);
    check("to_err",    {31'd0, rsp_err},   32'd1);
    check("to_rdat",   rsp_dat,            32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // ack on the last allowed cycle wins over timeout
    slave_en = 1; ws = 7; rdat = 32'hCAFE_F00D;
    issue(1'b0, 32'h0000_0300, 32'd0, 4'hF);
    for (int i = 0; i < 8; i++) step();
    check("sim_ncyc",   cyc_cycles,         32'd8);
    check("sim_rvalid", {31'd0, rsp_valid}, 32'd1);
    check("sim_err",    {31'd0, rsp_err},   32'd0);
    check("sim_rdat",   rsp_dat,            32'hCAFE_F00D);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // reset pulse during a read wait
    slave_en = 0; rdat = 32'h5A5A_5A5A;
    issue(1'b0, 32'h0000_0400, 32'd0, 4'hF);
    step();
    check("ra_cyc_before", {31'd0, cyc}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("ra_cyc_async",  {31'd0, cyc},  32'd0);
    check("ra_stb_async",  {31'd0, stb},  32'd0);
    check("ra_busy_async", {31'd0, busy}, 32'd0);
    check("ra_adr_async",  adr,           32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check("ra_ready",  {31'd0, cmd_ready}, 32'd1);
    check("ra_rvalid", {31'd0, rsp_valid}, 32'd0);
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    check("spur_rvalid", {31'd0, rsp_valid}, 32'd0);
    check("spur_busy",   {31'd0, busy},      32'd0);
    check("spur_rdat",   rsp_dat,            32'd0);
    check("spur_cyc",    {31'd0, cyc},       32'd0);
    step();

    // back-to-back commands with response always consumed
    slave_en = 1; ws = 0; rsp_ready = 1'b1; rdat = 32'h0000_0011;
    cmd_we = 0; cmd_adr = 32'h0000_0A00; cmd_dat = 0; cmd_sel = 4'hF;
    cmd_valid = 1'b1;
    step();
    check("b2b_cyc1", {31'd0, cyc}, 32'd1);
    check("b2b_adr1", adr,          32'h0000_0A00);
    cmd_adr = 32'h0000_0B00;
    check("b2b_busy_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    check("b2b_resp_cyc",   {31'd0, cyc},       32'd0);
    check("b2b_resp_ready", {31'd0, cmd_ready}, 32'd0);
    check("b2b_resp_valid", {31'd0, rsp_valid}, 32'd1);
    check("b2b_rdat1",      rsp_dat,            32'h0000_0011);
    step();
    check("b2b_idle_cyc",   {31'd0, cyc},       32'd0);
    check("b2b_idle_ready", {31'd0, cmd_ready}, 32'd1);
    check("b2b_idle_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    cmd_valid = 1'b0;
    check("b2b_cyc2", {31'd0, cyc}, 32'd1);
    check("b2b_adr2", adr,          32'h0000_0B00);
    step();
    check("b2b_rvalid2", {31'd0, rsp_valid}, 32'd1);
    step();
    rsp_ready = 1'b0;
    check("b2b_done", {31'd0, busy}, 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
